// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: synchronised, debounced serial-clock frame receiver with parity, overrun and timeout detection
module serial_frame_receiver #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_clk_in,
    input  logic                 serial_data_in,
    input  logic                 data_ready,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun,
    output logic                 frame_timeout
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    logic [1:0] sync1_q, sync2_q, db_q, db_d;
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];
    logic clk_prev_q, fall, sdat, par_bad, good;
    state_t state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [TW-1:0] to_q, to_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
    logic par_q, par_d, dv_q, dv_d;
    logic pe_q, pe_d, fe_q, fe_d, ov_q, ov_d, tp_q, tp_d;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end
    assign fall    = clk_prev_q & ~db_q[0];
    assign sdat    = db_q[1];
    assign par_bad = (PARITY_MODE == 1) ? ~^{shift_q, par_q} : ^{shift_q, par_q};
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pe_d    = 1'b0;
        fe_d    = 1'b0;
        tp_d    = 1'b0;
        good    = 1'b0;
        to_d    = (state_q == IDLE || fall) ? '0 : to_q + TW'(1);
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!sdat) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else fe_d = 1'b1;
                end
                DATA: begin
                    shift_d = {sdat, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == BW'(DATA_BITS - 1)) state_d = (PARITY_MODE == 0) ? STOP : PARITY;
                end
                PARITY: begin
                    par_d   = sdat;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    fe_d    = ~sdat;
                    pe_d    = (PARITY_MODE != 0) && par_bad;
                    good    = sdat && !pe_d;
                end
            endcase
        end else if (state_q != IDLE && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            tp_d    = 1'b1;
            to_d    = '0;
        end
    end
    always_comb begin
        dv_d   = dv_q & ~data_ready;
        dout_d = dout_q;
        ov_d   = 1'b0;
        if (good) begin
            if (dv_q && !data_ready) ov_d = 1'b1;
            else begin
                dv_d   = 1'b1;
                dout_d = shift_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            db_q       <= 2'b11;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_q      <= '0;
            to_q       <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            dout_q     <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
            tp_q       <= 1'b0;
        end else begin
            sync1_q    <= {serial_data_in, serial_clk_in};
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            clk_prev_q <= db_q[0];
            state_q    <= state_d;
            bit_q      <= bit_d;
            to_q       <= to_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
            tp_q       <= tp_d;
        end
    end
    assign data_valid    = dv_q;
    assign data_out      = dout_q;
    assign parity_error  = pe_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
    assign frame_timeout = tp_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed checks on an 8-bit odd-parity receiver and a 9-bit no-parity receiver
module tb_serial_frame_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk0 = 1'b1, sdat0 = 1'b1, ready0 = 1'b1;
    logic sclk1 = 1'b1, sdat1 = 1'b1, ready1 = 1'b1;
    logic dv0, pe0, fe0, ov0, to0, dv1, pe1, fe1, ov1, to1;
    logic [7:0] dout0;
    logic [8:0] dout1;
    int checks = 0, errors = 0;
    int dv0_n = 0, pe0_n = 0, fe0_n = 0, ov0_n = 0, to0_n = 0, dv1_n = 0;
    int s_dv, s_pe, s_fe, s_ov, s_to, s_dv1;
    logic [7:0] last_d0;
    logic [8:0] last_d1;
    always #5 clk = ~clk;
    serial_frame_receiver #(.DATA_BITS(8), .PARITY_MODE(1), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) u0 (
        .clk(clk), .rst(rst), .serial_clk_in(sclk0), .serial_data_in(sdat0), .data_ready(ready0),
        .data_valid(dv0), .data_out(dout0), .parity_error(pe0), .framing_error(fe0),
        .overrun(ov0), .frame_timeout(to0));
    serial_frame_receiver #(.DATA_BITS(9), .PARITY_MODE(0), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)) u1 (
        .clk(clk), .rst(rst), .serial_clk_in(sclk1), .serial_data_in(sdat1), .data_ready(ready1),
        .data_valid(dv1), .data_out(dout1), .parity_error(pe1), .framing_error(fe1),
        .overrun(ov1), .frame_timeout(to1));
    always @(negedge clk) begin
        dv0_n += int'(dv0);
        pe0_n += int'(pe0);
        fe0_n += int'(fe0);
        ov0_n += int'(ov0);
        to0_n += int'(to0);
        dv1_n += int'(dv1);
        if (dv0) last_d0 = dout0;
        if (dv1) last_d1 = dout1;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic snap();
        s_dv = dv0_n; s_pe = pe0_n; s_fe = fe0_n; s_ov = ov0_n; s_to = to0_n; s_dv1 = dv1_n;
    endtask
    task automatic send_bit(input int w, input logic b);
        @(negedge clk);
        if (w == 0) sdat0 = b; else sdat1 = b;
        repeat (8) @(negedge clk);
        if (w == 0) sclk0 = 1'b0; else sclk1 = 1'b0;
        repeat (8) @(negedge clk);
        if (w == 0) sclk0 = 1'b1; else sclk1 = 1'b1;
    endtask
    task automatic send_frame(input int w, input logic [15:0] pl, input int n, input bit usep, input logic p, input logic stop);
        send_bit(w, 1'b0);
        for (int i = 0; i < n; i++) send_bit(w, pl[i]);
        if (usep) send_bit(w, p);
        send_bit(w, stop);
        if (w == 0) sdat0 = 1'b1; else sdat1 = 1'b1;
        repeat (6) @(negedge clk);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dv0", 32'(dv0), 0);
        chk("rst_dout0", 32'(dout0), 0);
        chk("rst_pulses0", 32'({pe0, fe0, ov0, to0}), 0);
        chk("rst_dv1", 32'(dv1), 0);
        chk("rst_dout1", 32'(dout1), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        // 0xA5 has four ones, so odd parity needs parity bit 1
        snap();
        send_frame(0, 16'h00A5, 8, 1, 1'b1, 1'b1);
        chk("a5_dv_cycles", 32'(dv0_n - s_dv), 1);
        chk("a5_dout", 32'(last_d0), 32'hA5);
        chk("a5_no_err", 32'(pe0_n - s_pe + fe0_n - s_fe + ov0_n - s_ov), 0);
        snap();
        send_frame(0, 16'h003C, 8, 1, 1'b0, 1'b1);
        chk("3c_p0_pe", 32'(pe0_n - s_pe), 1);
        chk("3c_p0_dv", 32'(dv0_n - s_dv), 0);
        chk("3c_p0_fe", 32'(fe0_n - s_fe), 0);
        snap();
        send_frame(0, 16'h003C, 8, 1, 1'b1, 1'b1);
        chk("3c_p1_pe", 32'(pe0_n - s_pe), 0);
        chk("3c_p1_dv", 32'(dv0_n - s_dv), 1);
        chk("3c_p1_dout", 32'(last_d0), 32'h3C);
        ready0 = 1'b0;
        send_frame(0, 16'h0011, 8, 1, 1'b1, 1'b1);
        chk("ov_first_dv", 32'(dv0), 1);
        chk("ov_first_dout", 32'(dout0), 32'h11);
        snap();
        send_frame(0, 16'h0022, 8, 1, 1'b1, 1'b1);
        chk("ov_pulse", 32'(ov0_n - s_ov), 1);
        chk("ov_dout_kept", 32'(dout0), 32'h11);
        chk("ov_dv_kept", 32'(dv0), 1);
        ready0 = 1'b1;
        @(negedge clk);
        chk("ov_accept_clear", 32'(dv0), 0);
        // a 3-cycle low glitch is one short of the debounce window
        snap();
        sclk0 = 1'b0;
        repeat (3) @(negedge clk);
        sclk0 = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_no_fe", 32'(fe0_n - s_fe), 0);
        chk("glitch_no_dv", 32'(dv0_n - s_dv), 0);
        snap();
        send_bit(0, 1'b1);
        repeat (6) @(negedge clk);
        chk("idle_data1_fe", 32'(fe0_n - s_fe), 1);
        snap();
        send_frame(0, 16'h0000, 8, 1, 1'b1, 1'b0);
        chk("stop0_fe", 32'(fe0_n - s_fe), 1);
        chk("stop0_pe", 32'(pe0_n - s_pe), 0);
        chk("stop0_dv", 32'(dv0_n - s_dv), 0);
        snap();
        send_frame(0, 16'h0000, 8, 1, 1'b0, 1'b0);
        chk("both_fe", 32'(fe0_n - s_fe), 1);
        chk("both_pe", 32'(pe0_n - s_pe), 1);
        chk("both_dv", 32'(dv0_n - s_dv), 0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        sdat0 = 1'b1;
        snap();
        repeat (88) @(negedge clk);
        chk("to_not_early", 32'(to0_n - s_to), 0);
        repeat (20) @(negedge clk);
        chk("to_pulse", 32'(to0_n - s_to), 1);
        chk("to_no_fe", 32'(fe0_n - s_fe), 0);
        snap();
        send_frame(0, 16'h005A, 8, 1, 1'b1, 1'b1);
        chk("after_to_dv", 32'(dv0_n - s_dv), 1);
        chk("after_to_dout", 32'(last_d0), 32'h5A);
        chk("after_to_err", 32'(pe0_n - s_pe + fe0_n - s_fe), 0);
        snap();
        send_frame(1, 16'h01FF, 9, 0, 1'b0, 1'b1);
        chk("w9_dv", 32'(dv1_n - s_dv1), 1);
        chk("w9_dout", 32'(last_d1), 32'h1FF);
        ready1 = 1'b0;
        send_frame(1, 16'h00AA, 9, 0, 1'b0, 1'b1);
        chk("w9_pending", 32'(dv1), 1);
        send_bit(1, 1'b0);
        send_bit(1, 1'b1);
        send_bit(1, 1'b1);
        send_bit(1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dv1", 32'(dv1), 0);
        chk("midrst_dout1", 32'(dout1), 0);
        chk("midrst_pulses1", 32'({pe1, fe1, ov1, to1}), 0);
        chk("midrst_dv0", 32'(dv0), 0);
        chk("midrst_dout0", 32'(dout0), 0);
        rst = 1'b0;
        ready1 = 1'b1;
        sdat1 = 1'b1;
        repeat (4) @(negedge clk);
        snap();
        send_frame(1, 16'h0155, 9, 0, 1'b0, 1'b1);
        chk("post_rst_dv", 32'(dv1_n - s_dv1), 1);
        chk("post_rst_dout", 32'(last_d1), 32'h155);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
